// File: rtl/bias_load_ctrl.sv
// Bias buffer load sequencer: packs K_CHANNELS stream words per row and writes rows from a base address.
// Optional XOR checksum of transferred words is enabled by defining BIAS_LOAD_CHECKSUM_EN.

package bias_pkg;
    localparam int K_CHANNELS = 4;
    localparam int ACC_WIDTH  = 32;
endpackage

module bias_load_ctrl
    import bias_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                            clk_i,
    input  logic                            rst_async_n_i,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic [ADDR_W-1:0]               cfg_base_addr_i,
    input  logic [ADDR_W:0]                 cfg_num_rows_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            cfg_err_o,
    input  logic                            s_valid_i,
    output logic                            s_ready_o,
    input  logic [ACC_WIDTH-1:0]            s_data_i,
    output logic                            wr_en_o,
    output logic [ADDR_W-1:0]               wr_addr_o,
    output logic [K_CHANNELS*ACC_WIDTH-1:0] wr_data_o
`ifdef BIAS_LOAD_CHECKSUM_EN
    ,
    output logic [ACC_WIDTH-1:0]            checksum_o
`endif
);

    localparam int LANE_W = (K_CHANNELS > 1) ? $clog2(K_CHANNELS) : 1;
    localparam int ROW_W  = K_CHANNELS * ACC_WIDTH;
    localparam int SUM_W  = ADDR_W + 2;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(K_CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                   r_s_ready;
    logic                   r_done;
    logic                   r_cfg_err;
    logic                   r_wr_en;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [ROW_W-1:0]       r_wr_data;
    logic [ADDR_W-1:0]      r_next_addr;
    logic [ADDR_W:0]        r_num_rows;
    logic [ADDR_W:0]        r_row_cnt;
    logic [LANE_W-1:0]      r_lane;
    logic [ACC_WIDTH-1:0]   r_pack [K_CHANNELS-1];

    logic                   w_busy;
    logic                   w_ready_nxt;
    logic                   w_start_req;
    logic                   w_range_err;
    logic                   w_start_ok;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_zero;
    logic                   w_xfer;
    logic                   w_load_xfer;
    logic                   w_last_lane;
    logic                   w_last_row;
    logic                   w_row_done;
    logic                   w_take_lane;
    logic [SUM_W-1:0]       w_sum;
    logic [ADDR_W:0]        w_row_cnt_inc;
    logic [ROW_W-1:0]       w_row;

    // Start qualification: abort wins over start, and the range check is done wide enough not to wrap.
    assign w_start_req   = start_i & ~abort_i;
    assign w_sum         = SUM_W'(cfg_base_addr_i) + SUM_W'(cfg_num_rows_i);
    assign w_range_err   = (w_sum > SUM_W'(DEPTH));
    assign w_start_ok    = w_start_req & ~w_range_err & (cfg_num_rows_i != '0);
    assign w_accept      = (r_state == ST_IDLE) & w_start_ok;
    assign w_reject      = (r_state == ST_IDLE) & w_start_req & w_range_err;
    assign w_zero        = (r_state == ST_IDLE) & w_start_req & ~w_range_err & (cfg_num_rows_i == '0);

    assign w_xfer        = s_valid_i & r_s_ready;
    assign w_load_xfer   = (r_state == ST_LOAD) & w_xfer & ~abort_i;
    assign w_last_lane   = (r_lane == LAST_LANE);
    assign w_row_cnt_inc = r_row_cnt + (ADDR_W + 1)'(1);
    assign w_last_row    = (w_row_cnt_inc == r_num_rows);
    assign w_row_done    = w_load_xfer & w_last_lane;
    assign w_take_lane   = w_load_xfer & ~w_last_lane;

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: default assignment first so no path through the case leaves the signal unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_xfer && w_last_lane && w_last_row) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_busy      = (r_state != ST_IDLE);
        w_ready_nxt = (w_state_nxt == ST_LOAD);
    end

    // Complete row: buffered lanes plus the word transferring this cycle in the top lane.
    always_comb begin
        w_row = '0;
        for (int k = 0; k < K_CHANNELS - 1; k++) begin
            w_row[k*ACC_WIDTH +: ACC_WIDTH] = r_pack[k];
        end
        w_row[(K_CHANNELS-1)*ACC_WIDTH +: ACC_WIDTH] = s_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            r_s_ready   <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_next_addr <= '0;
            r_num_rows  <= '0;
            r_row_cnt   <= '0;
            r_lane      <= '0;
            // NOTE: the pack register is only K-1 words of flops, so resetting it is cheap and keeps it X-free.
            for (int k = 0; k < K_CHANNELS - 1; k++) begin
                r_pack[k] <= '0;
            end
        end else begin
            r_s_ready <= w_ready_nxt;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_wr_en   <= 1'b0;

            if (w_reject) begin
                r_cfg_err <= 1'b1;
            end
            if (w_zero) begin
                r_done <= 1'b1;
            end
            if (w_accept) begin
                r_next_addr <= cfg_base_addr_i;
                r_num_rows  <= cfg_num_rows_i;
                r_row_cnt   <= '0;
                r_lane      <= '0;
            end

            // The last lane goes straight into the output register, freeing the pack register at once.
            if (w_row_done) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_next_addr;
                r_wr_data <= w_row;
                r_lane    <= '0;
                if (w_last_row) begin
                    r_done <= 1'b1;
                end else begin
                    r_row_cnt   <= w_row_cnt_inc;
                    r_next_addr <= r_next_addr + ADDR_W'(1);
                end
            end else if (w_take_lane) begin
                r_pack[r_lane] <= s_data_i;
                r_lane         <= r_lane + LANE_W'(1);
            end
        end
    end

    assign busy_o    = w_busy;
    assign done_o    = r_done;
    assign cfg_err_o = r_cfg_err;
    assign s_ready_o = r_s_ready;
    assign wr_en_o   = r_wr_en;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;

`ifdef BIAS_LOAD_CHECKSUM_EN
    logic [ACC_WIDTH-1:0] r_checksum;

    // Survives abort and completion; only an accepted start clears it.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum ^ s_data_i;
        end
    end

    assign checksum_o = r_checksum;
`endif

endmodule

// File: tb/tb_bias_load_ctrl.sv
// Self-checking bench for bias_load_ctrl: word-count based reference model, per-cycle compare, directed and random jobs.
module tb_bias_load_ctrl;
    import bias_pkg::*;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int K      = K_CHANNELS;
    localparam int W      = ACC_WIDTH;
    localparam int ROW_W  = K * W;

    logic              clk;
    logic              rst_n;
    logic              start_i;
    logic              abort_i;
    logic [ADDR_W-1:0] cfg_base_addr_i;
    logic [ADDR_W:0]   cfg_num_rows_i;
    logic              busy_o;
    logic              done_o;
    logic              cfg_err_o;
    logic              s_valid_i;
    logic              s_ready_o;
    logic [W-1:0]      s_data_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [ROW_W-1:0]  wr_data_o;
`ifdef BIAS_LOAD_CHECKSUM_EN
    logic [W-1:0]      checksum_o;
`endif

    bias_load_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i           (clk),
        .rst_async_n_i   (rst_n),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .cfg_base_addr_i (cfg_base_addr_i),
        .cfg_num_rows_i  (cfg_num_rows_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .cfg_err_o       (cfg_err_o),
        .s_valid_i       (s_valid_i),
        .s_ready_o       (s_ready_o),
        .s_data_i        (s_data_i),
        .wr_en_o         (wr_en_o),
        .wr_addr_o       (wr_addr_o),
        .wr_data_o       (wr_data_o)
`ifdef BIAS_LOAD_CHECKSUM_EN
        ,
        .checksum_o      (checksum_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: tracks words taken in the current job; writes, done and ready follow from counts.
    logic              m_busy, m_ready, m_wr_en, m_done, m_err;
    logic [ADDR_W-1:0] m_addr;
    logic [ROW_W-1:0]  m_data;
    logic [W-1:0]      m_csum;
    int                m_base, m_rows, m_taken;
    logic [W-1:0]      m_words [DEPTH*K];

    always @(posedge clk or negedge rst_n) begin : p_model
        logic xfer;
        int   row;
        if (!rst_n) begin
            m_busy = 0; m_ready = 0; m_wr_en = 0; m_done = 0; m_err = 0;
            m_addr = '0; m_data = '0; m_csum = '0;
            m_base = 0; m_rows = 0; m_taken = 0;
        end else begin
            xfer = m_ready && s_valid_i;
            if (xfer) m_csum = m_csum ^ s_data_i;
            m_wr_en = 0; m_done = 0; m_err = 0;
            if (!m_busy) begin
                if (start_i && !abort_i) begin
                    if (int'(cfg_base_addr_i) + int'(cfg_num_rows_i) > DEPTH) m_err = 1;
                    else if (cfg_num_rows_i == 0) m_done = 1;
                    else begin
                        m_base = int'(cfg_base_addr_i);
                        m_rows = int'(cfg_num_rows_i);
                        m_taken = 0; m_csum = '0; m_busy = 1; m_ready = 1;
                    end
                end
            end else if (abort_i || m_taken == m_rows * K) begin
                m_busy = 0; m_ready = 0;
            end else if (xfer) begin
                m_words[m_taken] = s_data_i;
                m_taken++;
                if (m_taken % K == 0) begin
                    row = m_taken / K - 1;
                    m_wr_en = 1;
                    m_addr = ADDR_W'(m_base + row);
                    for (int k = 0; k < K; k++) m_data[k*W +: W] = m_words[row*K + k];
                    if (m_taken == m_rows * K) begin
                        m_done = 1; m_ready = 0;
                    end
                end
            end
        end
    end

    typedef struct {
        int               c;
        logic [ADDR_W-1:0] addr;
        logic [ROW_W-1:0]  data;
    } wr_rec_t;

    wr_rec_t      wr_log[$];
    int           done_log[$];
    int           err_cnt, ready_cnt, busy_cnt;
    logic [W-1:0] csum_at_done;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        check("busy", busy_o, m_busy);
        check("ready", s_ready_o, m_ready);
        check("wr_en", wr_en_o, m_wr_en);
        check("done", done_o, m_done);
        check("cfg_err", cfg_err_o, m_err);
        check("wr_addr", wr_addr_o, m_addr);
        check("wr_data", wr_data_o, m_data);
`ifdef BIAS_LOAD_CHECKSUM_EN
        check("checksum", checksum_o, m_csum);
        if (done_o) csum_at_done = checksum_o;
`endif
        if (wr_en_o) wr_log.push_back('{cyc, wr_addr_o, wr_data_o});
        if (done_o) done_log.push_back(cyc);
        if (cfg_err_o) err_cnt++;
        if (s_ready_o) ready_cnt++;
        if (busy_o) busy_cnt++;
    end

    task automatic clear_logs();
        wr_log.delete(); done_log.delete();
        err_cnt = 0; ready_cnt = 0; busy_cnt = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start_job(input int b, input int r);
        start_i = 1'b1;
        cfg_base_addr_i = ADDR_W'(b);
        cfg_num_rows_i = (ADDR_W + 1)'(r);
        step();
        start_i = 1'b0;
    endtask

    // vmode: 0 valid held, 1 valid toggles, 2 random valid
    task automatic feed(input int n, input logic [W-1:0] first, input int vmode, input bit rnd);
        int  sent = 0;
        int  c = 0;
        bit  v, x;
        while (sent < n && c < 4000) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            s_valid_i = v;
            s_data_i = rnd ? W'($urandom()) : first + W'(sent);
            x = v && s_ready_o;
            step();
            if (x) sent++;
            c++;
        end
        s_valid_i = 1'b0;
        if (sent < n) check("feed_timeout", sent, n);
    endtask

    task automatic abort_job();
        s_valid_i = 1'b0;
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check("abort_ready_low", s_ready_o, 0);
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy_o && c < 20) begin
            step();
            c++;
        end
        if (busy_o) check("idle_timeout", busy_o, 0);
        step();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_ready"}, s_ready_o, 0);
        check({tag, "_wr_en"}, wr_en_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, cfg_err_o, 0);
        check({tag, "_addr"}, wr_addr_o, 0);
        check({tag, "_data"}, wr_data_o, 0);
    endtask

    initial begin : p_watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : p_stim
        int b, r;
        rst_n = 1'b0; start_i = 0; abort_i = 0; s_valid_i = 0; s_data_i = '0;
        cfg_base_addr_i = '0; cfg_num_rows_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_outputs_zero("reset");
        step();

        // 1: two rows, words 1..8 back to back
        clear_logs();
        start_job(5, 2);
        feed(8, 32'd1, 0, 1'b0);
        wait_idle();
        check("t1_nwr", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            check("t1_addr0", wr_log[0].addr, 5);
            check("t1_data0", wr_log[0].data, 128'h00000004_00000003_00000002_00000001);
            check("t1_addr1", wr_log[1].addr, 6);
            check("t1_data1", wr_log[1].data, 128'h00000008_00000007_00000006_00000005);
            check("t1_done_with_last_wr", done_log.size() == 1 && done_log[0] == wr_log[1].c, 1);
            check("t1_wr_gap", wr_log[1].c - wr_log[0].c, 4);
        end
        check("t1_ready_cycles", ready_cnt, 8);
        check("t1_busy_cycles", busy_cnt, 9);
`ifdef BIAS_LOAD_CHECKSUM_EN
        check("t6_checksum", csum_at_done, 32'h8);
`endif

        // 2: out-of-range start, then zero-row start
        clear_logs();
        start_job(62, 3);
        repeat (3) step();
        check("t2_err_cnt", err_cnt, 1);
        check("t2_err_nwr", wr_log.size(), 0);
        check("t2_err_busy", busy_cnt, 0);
        clear_logs();
        start_job(0, 0);
        repeat (3) step();
        check("t2_zero_done", done_log.size(), 1);
        check("t2_zero_nwr", wr_log.size(), 0);
        check("t2_zero_busy", busy_cnt, 0);

        // 3: single row with valid toggling
        clear_logs();
        start_job(10, 1);
        feed(4, 32'hA, 1, 1'b0);
        wait_idle();
        check("t3_nwr", wr_log.size(), 1);
        if (wr_log.size() == 1) begin
            check("t3_addr", wr_log[0].addr, 10);
            check("t3_data", wr_log[0].data, 128'h0000000D_0000000C_0000000B_0000000A);
        end
        check("t3_done", done_log.size(), 1);

        // 4: abort after six words, then a clean job
        clear_logs();
        start_job(20, 2);
        feed(6, 32'd1, 0, 1'b0);
        abort_job();
        repeat (5) step();
        check("t4_nwr", wr_log.size(), 1);
        if (wr_log.size() == 1) begin
            check("t4_addr", wr_log[0].addr, 20);
            check("t4_data", wr_log[0].data, 128'h00000004_00000003_00000002_00000001);
        end
        check("t4_no_done", done_log.size(), 0);
        clear_logs();
        start_job(0, 1);
        feed(4, 32'h11, 0, 1'b0);
        wait_idle();
        check("t4b_nwr", wr_log.size(), 1);
        if (wr_log.size() == 1) begin
            check("t4b_addr", wr_log[0].addr, 0);
            check("t4b_data", wr_log[0].data, 128'h00000014_00000013_00000012_00000011);
        end

        // 5: start while busy is ignored; reset mid-row clears everything at once
        clear_logs();
        start_job(30, 2);
        feed(2, 32'h100, 0, 1'b0);
        start_job(1, 1);
        feed(6, 32'h102, 0, 1'b0);
        wait_idle();
        check("t5_nwr", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            check("t5_addr0", wr_log[0].addr, 30);
            check("t5_data0", wr_log[0].data, 128'h00000103_00000102_00000101_00000100);
            check("t5_addr1", wr_log[1].addr, 31);
        end
        start_job(40, 2);
        feed(2, 32'h200, 0, 1'b0);
        #3 rst_n = 1'b0;
        #1 check_outputs_zero("t5_async_rst");
        step();
        rst_n = 1'b1;
        clear_logs();
        repeat (5) step();
        check("t5_post_rst_nwr", wr_log.size(), 0);
        check("t5_post_rst_busy", busy_cnt, 0);

        // Abort and start together in IDLE: start ignored
        start_i = 1'b1; abort_i = 1'b1; cfg_base_addr_i = '0; cfg_num_rows_i = 7'd1;
        step();
        start_i = 1'b0; abort_i = 1'b0;
        check("abort_start_busy", busy_o, 0);

        // Boundaries: full buffer, last row, one past the end
        clear_logs();
        start_job(0, 64);
        feed(256, 32'h1000, 0, 1'b0);
        wait_idle();
        check("full_nwr", wr_log.size(), 64);
        if (wr_log.size() == 64) check("full_last_addr", wr_log[63].addr, 63);
        check("full_done", done_log.size(), 1);
        clear_logs();
        start_job(63, 1);
        feed(4, 32'h55, 2, 1'b0);
        wait_idle();
        check("last_row_nwr", wr_log.size(), 1);
        clear_logs();
        start_job(63, 2);
        repeat (2) step();
        check("past_end_err", err_cnt, 1);

        // Random jobs; the per-cycle compare does the checking
        for (int j = 0; j < 30; j++) begin
            b = $urandom_range(0, 63);
            r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 64) : $urandom_range(0, 6);
            start_job(b, r);
            if (r != 0 && b + r <= DEPTH) begin
                if ($urandom_range(0, 3) == 0) begin
                    feed($urandom_range(1, r * K - 1), '0, 2, 1'b1);
                    abort_job();
                end else begin
                    feed(r * K, '0, 2, 1'b1);
                end
                wait_idle();
            end else begin
                repeat (2) step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bias_load_ctrl.md
Name: bias_load_ctrl

Overview:
Load sequencer for the bias buffer. It accepts a narrow valid/ready stream of ACC_WIDTH bias words and packs K_CHANNELS consecutive words into one row. It then issues row writes on the bias buffer's loader write port (write enable, address, data), starting at a programmed base address. It sits between the layer configuration logic (start/abort, base, row count) and the bias buffer, and reports busy/done/error status back to the layer configuration logic.

Parameters:
DEPTH, 64, number of rows in the target bias buffer
ADDR_W, $clog2(DEPTH), row address width
(K_CHANNELS and ACC_WIDTH are taken from the shared definitions package, not parameters)

Ports:
clk_i  in  1  clock
rst_async_n_i  in  1  asynchronous active-low reset
start_i  in  1  launch a job; sampled only in IDLE
abort_i  in  1  cancel the job in progress
cfg_base_addr_i  in  ADDR_W  first row address; latched on accepted start
cfg_num_rows_i  in  ADDR_W+1  rows to load, 0..DEPTH; latched on accepted start
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse at job completion
cfg_err_o  out  1  one-cycle pulse when a start is rejected
s_valid_i  in  1  stream word valid
s_ready_o  out  1  stream word ready
s_data_i  in  ACC_WIDTH  bias word (signed, two's complement)
wr_en_o  out  1  bias buffer write enable (registered)
wr_addr_o  out  ADDR_W  bias buffer write row (registered)
wr_data_o  out  K_CHANNELS*ACC_WIDTH  packed row (registered); lane k is bits [k*ACC_WIDTH +: ACC_WIDTH]

Behaviour:
- Reset: state IDLE; all counters zero; every output 0 (busy_o, done_o, cfg_err_o, s_ready_o, wr_en_o, wr_addr_o, wr_data_o).
- States: IDLE, LOAD, FLUSH.
- Start acceptance: start_i is accepted in IDLE only; it is ignored while busy_o=1.
- Rejected start: if cfg_base_addr_i + cfg_num_rows_i > DEPTH, pulse cfg_err_o for one cycle, stay in IDLE, issue no writes.
- Zero-row start: if cfg_num_rows_i == 0, pulse done_o on the next cycle, stay in IDLE, issue no writes.
- Valid start: otherwise latch base and row count and enter LOAD next cycle. busy_o=1 in LOAD and FLUSH.
- LOAD: s_ready_o=1, registered (first high the cycle after start). A beat transfers when s_valid_i and s_ready_o are both high.
- Lane packing: the lane counter (0..K_CHANNELS-1) selects the pack-register lane; lane 0 is the first word of a row.
- Row write: when the lane-(K_CHANNELS-1) word transfers, the next cycle has wr_en_o=1, wr_addr_o = base + row index, and wr_data_o = the complete row (including that last word). wr_en_o is a single-cycle pulse.
- Throughput: a separate output register lets the pack register accept the next row's lane 0 in the same cycle. Sustained rate is 1 word/cycle with no bubbles.
- Last row: when the final word of the final row transfers, go to FLUSH. s_ready_o=0 from the next cycle.
- FLUSH (1 cycle): wr_en_o=1 for the final row and done_o=1 in the same cycle; next state is IDLE with busy_o=0.
- Outputs at rest: wr_addr_o and wr_data_o hold their last values when wr_en_o=0.
- Abort: abort_i in LOAD or FLUSH forces IDLE next cycle and drops s_ready_o. A write already registered in that cycle completes; no later write occurs; the partial row is discarded; no done_o. abort_i in IDLE has no effect. abort_i and start_i together in IDLE: abort has priority and the start is ignored.
- Asynchronous reset mid-job: everything returns to reset values immediately; no further writes.
- Row counter: width ADDR_W+1. Address arithmetic never wraps, guaranteed by the start check.

Optional Feature:
BIAS_LOAD_CHECKSUM_EN:
- Defined: adds output checksum_o [ACC_WIDTH].
  - Cleared to 0 on an accepted start.
  - XOR-accumulates every transferred s_data_i.
  - Holds its value after done_o until the next accepted start.
  - Reset value 0; not cleared by abort.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
(bench: K_CHANNELS=4, ACC_WIDTH=32, DEPTH=64)
1. Reset, then base=5, rows=2, stream words 1..8 with valid held high -> writes at addr 5 with data {4,3,2,1} (lane0=1), then addr 6 with {8,7,6,5}; 8 consecutive ready cycles; done_o in the same cycle as the addr-6 write; busy_o=0 one cycle later.
2. base=62, rows=3 -> cfg_err_o pulses once; no wr_en_o; busy_o stays 0. Then base=0, rows=0 -> done_o pulse next cycle, no writes.
3. base=10, rows=1, s_valid_i toggled 1/0 every cycle with words 0xA,0xB,0xC,0xD -> single write at addr 10 with data {D,C,B,A}; done_o after the 4th transfer.
4. base=20, rows=2, abort_i asserted after 6 words -> only the addr-20 write occurs; s_ready_o low the next cycle; no done_o. A new start with base=0, rows=1 then loads cleanly at addr 0.
5. start_i pulsed during a busy job -> ignored; latched base/rows unchanged. Reset asserted mid-row -> all outputs 0 immediately.
6. BIAS_LOAD_CHECKSUM_EN defined, words 1..8 -> checksum_o=0x8 at done_o.
